// File: rtl/balance_pid_param.sv
// Balance controller: PID on pitch error with soft-start ramp, saturating integrator,
// steering mix and overspeed flag. Motor commands and flag are registered.
module balance_pid_param #(
    parameter int              IN_W      = 16,
    parameter int              OUT_W     = 12,
    parameter int              SAT_W     = 10,
    parameter int              P_COEF    = 9,
    parameter int              I_W       = 18,
    parameter int              I_SHIFT   = 6,
    parameter int              D_SHIFT   = 6,
    parameter int              SS_W      = 9,
    parameter int              STW       = 12,
    parameter logic [STW-1:0]  STEER_MIN = 12'h200,
    parameter logic [STW-1:0]  STEER_MAX = 12'hE00,
    parameter int              FAST_THR  = 1536
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld,
    input  logic signed [IN_W-1:0]   ptch,
    input  logic signed [IN_W-1:0]   ptch_rt,
    input  logic                     pwr_up,
    input  logic                     rider_off,
    input  logic        [STW-1:0]    steer_pot,
    input  logic                     en_steer,
    output logic signed [OUT_W-1:0]  lft_spd,
    output logic signed [OUT_W-1:0]  rght_spd,
    output logic                     too_fast
);

    localparam int PW = OUT_W + 4;

    localparam logic signed [IN_W-1:0]  SAT_HI   = IN_W'(2**(SAT_W-1) - 1);
    localparam logic signed [IN_W-1:0]  SAT_LO   = IN_W'(-(2**(SAT_W-1)));
    localparam logic signed [OUT_W+1:0] P_K      = (OUT_W+2)'(P_COEF);
    localparam logic signed [I_W:0]     I_MAX    = (I_W+1)'(2**(I_W-1) - 1);
    localparam logic signed [I_W:0]     I_MIN    = (I_W+1)'(-(2**(I_W-1)));
    localparam logic signed [STW:0]     POT_MID  = (STW+1)'(2**(STW-1));
    localparam logic signed [STW+2:0]   STEER_K  = (STW+3)'(3);
    localparam logic signed [PW:0]      OUT_MAX  = (PW+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [PW:0]      OUT_MIN  = (PW+1)'(-(2**(OUT_W-1)));
    localparam logic signed [OUT_W-1:0] FAST_T   = OUT_W'(FAST_THR);

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [PW:0] v);
        logic signed [OUT_W-1:0] r;
        if (v > OUT_MAX) begin
            r = OUT_MAX[OUT_W-1:0];
        end else if (v < OUT_MIN) begin
            r = OUT_MIN[OUT_W-1:0];
        end else begin
            r = v[OUT_W-1:0];
        end
        return r;
    endfunction

    logic signed [I_W-1:0]     r_integ;
    logic        [SS_W-1:0]    r_ss_tmr;

    logic signed [SAT_W-1:0]   w_ptch_sat;
    logic signed [OUT_W+1:0]   w_p_term;
    logic signed [I_W:0]       w_integ_sum;
    logic signed [I_W-1:0]     w_integ_nxt;
    logic        [SS_W-1:0]    w_ss_nxt;
    logic signed [PW-1:0]      w_i_term;
    logic signed [PW-1:0]      w_d_term;
    logic signed [PW-1:0]      w_pid;
    logic signed [PW+SS_W:0]   w_pid_scaled;
    logic signed [PW-1:0]      w_pid_ss;
    logic        [STW-1:0]     w_pot_clip;
    logic signed [STW:0]       w_pot_c;
    logic signed [STW+2:0]     w_steer3;
    logic signed [PW-1:0]      w_steer;
    logic signed [OUT_W-1:0]   w_lft_sat;
    logic signed [OUT_W-1:0]   w_rght_sat;
    logic signed [OUT_W-1:0]   w_lft_nxt;
    logic signed [OUT_W-1:0]   w_rght_nxt;
    logic                      w_fast_nxt;

    // Pitch clip and proportional term
    always_comb begin
        if (ptch > SAT_HI) begin
            w_ptch_sat = SAT_HI[SAT_W-1:0];
        end else if (ptch < SAT_LO) begin
            w_ptch_sat = SAT_LO[SAT_W-1:0];
        end else begin
            w_ptch_sat = ptch[SAT_W-1:0];
        end
        w_p_term = (OUT_W+2)'(w_ptch_sat) * P_K;
    end

    // Integrator: clear has priority; accumulation clamps rather than wraps
    always_comb begin
        w_integ_sum = (I_W+1)'(r_integ) + (I_W+1)'(w_ptch_sat);
        if (rider_off) begin
            w_integ_nxt = {I_W{1'b0}};
        end else if (vld && pwr_up) begin
            if (w_integ_sum > I_MAX) begin
                w_integ_nxt = I_MAX[I_W-1:0];
            end else if (w_integ_sum < I_MIN) begin
                w_integ_nxt = I_MIN[I_W-1:0];
            end else begin
                w_integ_nxt = w_integ_sum[I_W-1:0];
            end
        end else begin
            w_integ_nxt = r_integ;
        end
    end

    // Soft-start counter and PID sum, scaled by the ramp until it saturates
    always_comb begin
        if (!pwr_up) begin
            w_ss_nxt = {SS_W{1'b0}};
        end else if (&r_ss_tmr) begin
            w_ss_nxt = r_ss_tmr;
        end else begin
            w_ss_nxt = r_ss_tmr + {{(SS_W-1){1'b0}}, 1'b1};
        end
        w_i_term     = PW'(r_integ >>> I_SHIFT);
        w_d_term     = -PW'(ptch_rt >>> D_SHIFT);
        w_pid        = PW'(w_p_term) + w_i_term + w_d_term;
        w_pid_scaled = (PW+SS_W+1)'(w_pid) * (PW+SS_W+1)'($signed({1'b0, r_ss_tmr}));
        if (&r_ss_tmr) begin
            w_pid_ss = w_pid;
        end else begin
            w_pid_ss = PW'(w_pid_scaled >>> SS_W);
        end
    end

    // Steering offset from the clipped, centred pot reading
    always_comb begin
        if (steer_pot < STEER_MIN) begin
            w_pot_clip = STEER_MIN;
        end else if (steer_pot > STEER_MAX) begin
            w_pot_clip = STEER_MAX;
        end else begin
            w_pot_clip = steer_pot;
        end
        w_pot_c  = $signed({1'b0, w_pot_clip}) - POT_MID;
        w_steer3 = (STW+3)'(w_pot_c) * STEER_K;
        if (en_steer) begin
            w_steer = PW'(w_steer3 >>> 4);
        end else begin
            w_steer = {PW{1'b0}};
        end
    end

    // Mix, saturate and gate by power
    always_comb begin
        w_lft_sat  = sat_out((PW+1)'(w_pid_ss) + (PW+1)'(w_steer));
        w_rght_sat = sat_out((PW+1)'(w_pid_ss) - (PW+1)'(w_steer));
        if (pwr_up) begin
            w_lft_nxt  = w_lft_sat;
            w_rght_nxt = w_rght_sat;
            w_fast_nxt = (w_lft_sat > FAST_T) || (w_rght_sat > FAST_T);
        end else begin
            w_lft_nxt  = {OUT_W{1'b0}};
            w_rght_nxt = {OUT_W{1'b0}};
            w_fast_nxt = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_integ  <= {I_W{1'b0}};
            r_ss_tmr <= {SS_W{1'b0}};
            lft_spd  <= {OUT_W{1'b0}};
            rght_spd <= {OUT_W{1'b0}};
            too_fast <= 1'b0;
        end else begin
            r_integ  <= w_integ_nxt;
            r_ss_tmr <= w_ss_nxt;
            lft_spd  <= w_lft_nxt;
            rght_spd <= w_rght_nxt;
            too_fast <= w_fast_nxt;
        end
    end

endmodule
